// File: rtl/temporal_bsg_pkg.sv
// Shared types and default sizing for the temporal (thermometer) bit-stream generator.
// Holds the FSM state enum and the default WIDTH/CWIDTH values.
package temporal_bsg_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_CWIDTH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/temporal_bsg_cnt.sv
// Stream cycle counter: synchronous clear, count enable, natural wrap, terminal flag.
// Ports: clk_i, rst_i (sync, active-high), clr_i, en_i -> cnt_d_o (next value), tc_o (cnt == max).
module temporal_bsg_cnt
    import temporal_bsg_pkg::*;
#(
    parameter int CWIDTH = DEF_CWIDTH
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              en_i,
    output logic [CWIDTH-1:0] cnt_d_o,
    output logic              tc_o
);

    localparam logic [CWIDTH-1:0] CNT_MAX = '1;

    logic [CWIDTH-1:0] cnt_q;
    logic [CWIDTH-1:0] cnt_d;

    // Wrap from max to zero falls out of the fixed width.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CWIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_d_o = cnt_d;
    assign tc_o    = (cnt_q == CNT_MAX);

endmodule

// File: rtl/temporal_bsg.sv
// Temporal bit-stream generator: turns a sign/magnitude operand into a 2^CWIDTH-cycle
// thermometer stream with mag leading ones. Optional macro TEMPORAL_BSG_ROUND_EN rounds
// the magnitude with the first dropped bit (saturating) instead of truncating.
// Ports: clk, rst (sync, active-high), i_clr, i_valid/i_ready, i_sign, i_abs[WIDTH-2:0]
//        -> o_valid, o_bit, o_sign, o_last.
module temporal_bsg
    import temporal_bsg_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int CWIDTH = DEF_CWIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic             i_sign,
    input  logic [WIDTH-2:0] i_abs,
    output logic             o_valid,
    output logic             o_bit,
    output logic             o_sign,
    output logic             o_last
);

    localparam logic [CWIDTH-1:0] CNT_MAX = '1;

    state_e            state_q;
    logic [CWIDTH-1:0] mag_q;
    logic              valid_q;
    logic              bit_q;
    logic              sign_q;
    logic              last_q;

    logic [CWIDTH-1:0] trunc;
    logic [CWIDTH-1:0] mag_in;
    logic [CWIDTH-1:0] cnt_d;
    logic              tc;
    logic              accept;
    logic              unused_abs;

    // Low-order magnitude bits only matter for the rounding guard bit.
    assign unused_abs = ^i_abs;

    assign trunc = i_abs[WIDTH-2 -: CWIDTH];

`ifdef TEMPORAL_BSG_ROUND_EN
    generate
        if (CWIDTH < WIDTH - 1) begin : g_round
            logic [CWIDTH:0] sum;
            assign sum    = {1'b0, trunc} + {{CWIDTH{1'b0}}, i_abs[WIDTH-2-CWIDTH]};
            assign mag_in = sum[CWIDTH] ? CNT_MAX : sum[CWIDTH-1:0];
        end else begin : g_no_guard
            assign mag_in = trunc;
        end
    endgenerate
`else
    assign mag_in = trunc;
`endif

    // A new operand can slip in on the final stream cycle, giving bubble-free streams.
    assign i_ready = !rst && !i_clr && ((state_q == IDLE) || last_q);
    assign accept  = i_valid && i_ready;

    temporal_bsg_cnt #(
        .CWIDTH (CWIDTH)
    ) u_cnt (
        .clk_i   (clk),
        .rst_i   (rst),
        .clr_i   (i_clr || accept || (state_q == IDLE)),
        .en_i    (state_q == RUN),
        .cnt_d_o (cnt_d),
        .tc_o    (tc)
    );

    // Outputs are computed from the counter's next value so they line up with cnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mag_q   <= '0;
            valid_q <= 1'b0;
            bit_q   <= 1'b0;
            sign_q  <= 1'b0;
            last_q  <= 1'b0;
        end else if (i_clr) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            bit_q   <= 1'b0;
            last_q  <= 1'b0;
        end else if (accept) begin
            state_q <= RUN;
            mag_q   <= mag_in;
            sign_q  <= i_sign;
            valid_q <= 1'b1;
            bit_q   <= (cnt_d < mag_in);
            last_q  <= (cnt_d == CNT_MAX);
        end else if ((state_q == RUN) && !tc) begin
            valid_q <= 1'b1;
            bit_q   <= (cnt_d < mag_q);
            last_q  <= (cnt_d == CNT_MAX);
        end else begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            bit_q   <= 1'b0;
            last_q  <= 1'b0;
        end
    end

    assign o_valid = valid_q;
    assign o_bit   = bit_q;
    assign o_sign  = sign_q;
    assign o_last  = last_q;

endmodule

// File: tb/tb_temporal_bsg.sv
// Directed self-checking bench for temporal_bsg at WIDTH=16, CWIDTH=4.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_temporal_bsg;

    localparam int W = 16;
    localparam int C = 4;
    localparam int N = 1 << C;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_clr;
    logic         i_valid;
    logic         i_ready;
    logic         i_sign;
    logic [W-2:0] i_abs;
    logic         o_valid;
    logic         o_bit;
    logic         o_sign;
    logic         o_last;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    temporal_bsg #(
        .WIDTH  (W),
        .CWIDTH (C)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (i_clr),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_sign  (i_sign),
        .i_abs   (i_abs),
        .o_valid (o_valid),
        .o_bit   (o_bit),
        .o_sign  (o_sign),
        .o_last  (o_last)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic chk_cyc(input string tag, input int k, input int ones,
                           input logic sgn);
        check($sformatf("%s_v%0d", tag, k), 32'(o_valid), 32'd1);
        check($sformatf("%s_b%0d", tag, k), 32'(o_bit), 32'(k < ones));
        check($sformatf("%s_s%0d", tag, k), 32'(o_sign), 32'(sgn));
        check($sformatf("%s_l%0d", tag, k), 32'(o_last), 32'(k == N - 1));
        check($sformatf("%s_r%0d", tag, k), 32'(i_ready), 32'(k == N - 1));
    endtask

    task automatic chk_idle(input string tag);
        check({tag, "_idle_v"}, 32'(o_valid), 32'd0);
        check({tag, "_idle_b"}, 32'(o_bit), 32'd0);
        check({tag, "_idle_l"}, 32'(o_last), 32'd0);
        check({tag, "_idle_r"}, 32'(i_ready), 32'd1);
    endtask

    // Called on a falling edge; the operand is accepted on the next rising edge.
    task automatic offer(input string tag, input logic [W-2:0] abs, input logic sgn);
        i_valid = 1'b1;
        i_abs   = abs;
        i_sign  = sgn;
        #1;
        check({tag, "_rdy"}, 32'(i_ready), 32'd1);
    endtask

    task automatic stream(input string tag, input logic [W-2:0] abs,
                          input logic sgn, input int ones);
        offer(tag, abs, sgn);
        @(negedge clk);
        i_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            chk_cyc(tag, k, ones, sgn);
            @(negedge clk);
        end
        chk_idle(tag);
    endtask

    initial begin
        rst     = 1'b1;
        i_clr   = 1'b0;
        i_valid = 1'b0;
        i_sign  = 1'b0;
        i_abs   = '0;

        @(negedge clk);
        @(negedge clk);
        check("rst_rdy", 32'(i_ready), 32'd0);
        check("rst_v", 32'(o_valid), 32'd0);
        check("rst_b", 32'(o_bit), 32'd0);
        check("rst_s", 32'(o_sign), 32'd0);
        check("rst_l", 32'(o_last), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_rdy", 32'(i_ready), 32'd1);
        @(negedge clk);

        stream("s1800", 15'h1800, 1'b1, 3);
`ifdef TEMPORAL_BSG_ROUND_EN
        stream("s1c00", 15'h1C00, 1'b0, 4);
`else
        stream("s1c00", 15'h1C00, 1'b0, 3);
`endif
        stream("s7fff", 15'h7FFF, 1'b1, 15);
        stream("s0000", 15'h0000, 1'b1, 0);

        // Back-to-back: zero stream then full-scale stream with i_valid held.
        offer("b2b", 15'h0000, 1'b0);
        @(negedge clk);
        for (int k = 0; k < 2 * N; k++) begin
            if (k == 0) begin
                i_abs  = 15'h7FFF;
                i_sign = 1'b1;
            end
            if (k == N) i_valid = 1'b0;
            check($sformatf("b2b_v%0d", k), 32'(o_valid), 32'd1);
            check($sformatf("b2b_b%0d", k), 32'(o_bit),
                  32'((k >= N) && (k - N < N - 1)));
            check($sformatf("b2b_s%0d", k), 32'(o_sign), 32'(k >= N));
            check($sformatf("b2b_l%0d", k), 32'(o_last), 32'(k % N == N - 1));
            check($sformatf("b2b_r%0d", k), 32'(i_ready), 32'(k % N == N - 1));
            @(negedge clk);
        end
        chk_idle("b2b");

        // Clear mid-stream with an operand offered at the same time.
        offer("clr", 15'h7FFF, 1'b0);
        @(negedge clk);
        i_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk_cyc("clr_a", k, 15, 1'b0);
            @(negedge clk);
        end
        chk_cyc("clr_a", 5, 15, 1'b0);
        i_clr   = 1'b1;
        i_valid = 1'b1;
        i_abs   = 15'h1800;
        i_sign  = 1'b1;
        #1;
        check("clr_rdy_low", 32'(i_ready), 32'd0);
        @(negedge clk);
        check("clr_v", 32'(o_valid), 32'd0);
        check("clr_b", 32'(o_bit), 32'd0);
        check("clr_l", 32'(o_last), 32'd0);
        check("clr_s_hold", 32'(o_sign), 32'd0);
        i_clr = 1'b0;
        #1;
        check("clr_rdy_high", 32'(i_ready), 32'd1);
        @(negedge clk);
        i_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            chk_cyc("clr_b", k, 3, 1'b1);
            @(negedge clk);
        end
        chk_idle("clr_b");

        // Reset mid-stream.
        offer("mrst", 15'h7FFF, 1'b1);
        @(negedge clk);
        i_valid = 1'b0;
        for (int k = 0; k < 9; k++) begin
            chk_cyc("mrst", k, 15, 1'b1);
            @(negedge clk);
        end
        chk_cyc("mrst", 9, 15, 1'b1);
        rst = 1'b1;
        #1;
        check("mrst_rdy_low", 32'(i_ready), 32'd0);
        @(negedge clk);
        check("mrst_v", 32'(o_valid), 32'd0);
        check("mrst_b", 32'(o_bit), 32'd0);
        check("mrst_s", 32'(o_sign), 32'd0);
        check("mrst_l", 32'(o_last), 32'd0);
        check("mrst_rdy_in_rst", 32'(i_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("mrst_rdy_after", 32'(i_ready), 32'd1);
        for (int k = 0; k < N + 4; k++) begin
            @(negedge clk);
            check($sformatf("mrst_quiet_v%0d", k), 32'(o_valid), 32'd0);
            check($sformatf("mrst_quiet_l%0d", k), 32'(o_last), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
